// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, field positions and exception codes for the
// P7 exception controller.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  localparam int unsigned SR_IM_LSB  = 10;
  localparam int unsigned SR_IM_MSB  = 15;
  localparam int unsigned SR_EXL_BIT = 1;
  localparam int unsigned SR_IE_BIT  = 0;

  // Cause fields
  localparam int unsigned CAUSE_BD_BIT  = 31;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_IP_MSB  = 15;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_EXC_MSB = 6;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_VEC_DEF = 32'h0000_4180;

endpackage

// File: rtl/cp0_exc_arbiter.sv
// Decides whether the M-stage instruction is interrupted or faults, and
// computes the ExcCode and EPC that the controller should record.
module cp0_exc_arbiter
  import cp0_pkg::*;
(
  input  logic [5:0]  sr_im,
  input  logic        sr_ie,
  input  logic        sr_exl,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  exc_code_m,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  output logic        int_req,
  output logic        ex_req,
  output logic [4:0]  exc_code_sel,
  output logic [31:0] epc_val
);

  assign int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign ex_req  = (exc_code_m != 5'd0) & ~sr_exl;

  // Interrupts take precedence even when the instruction also faulted.
  assign exc_code_sel = int_req ? 5'(EXC_INT) : exc_code_m;

  // A delay-slot victim restarts at its branch, one word earlier.
  assign epc_val = (pc_m & 32'hFFFF_FFFC) - (bd_m ? 32'd4 : 32'd0);

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: holds SR/Cause/EPC, raises the flush/redirect
// request and serves mtc0/mfc0 and the eret return address.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_VEC = HANDLER_VEC_DEF,
  parameter logic [31:0] PRID_VAL    = 32'h4B55_0701
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        exc_req,
  output logic [31:0] exc_pc,
  output logic [31:0] epc_out
);

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req, ex_req;
  logic [4:0]  exc_code_sel;
  logic [31:0] epc_val;
  logic [31:0] sr_word, cause_word;

  cp0_exc_arbiter u_arbiter (
    .sr_im        (sr_im_q),
    .sr_ie        (sr_ie_q),
    .sr_exl       (sr_exl_q),
    .hw_int       (hw_int),
    .exc_code_m   (exc_code_m),
    .pc_m         (pc_m),
    .bd_m         (bd_m),
    .int_req      (int_req),
    .ex_req       (ex_req),
    .exc_code_sel (exc_code_sel),
    .epc_val      (epc_val)
  );

  // Held low while in reset so a stale exc_code_m cannot redirect the pipe.
  assign exc_req = reset & (int_req | ex_req);
  assign exc_pc  = HANDLER_VEC;
  assign epc_out = epc_q;

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    cause_ip_d  = hw_int;
    if (exc_req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd_m;
      cause_exc_d = exc_code_sel;
      epc_d       = epc_val;
    end else begin
      if (eret_m) begin
        sr_exl_d = 1'b0;
      end
      // An mtc0 to SR in the same cycle as eret takes the written EXL.
      if (cp0_we && (cp0_addr == REG_SR)) begin
        sr_im_d  = cp0_wdata[SR_IM_MSB:SR_IM_LSB];
        sr_exl_d = cp0_wdata[SR_EXL_BIT];
        sr_ie_d  = cp0_wdata[SR_IE_BIT];
      end
      if (cp0_we && (cp0_addr == REG_EPC)) begin
        epc_d = {cp0_wdata[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    sr_word                          = '0;
    sr_word[SR_IM_MSB:SR_IM_LSB]     = sr_im_q;
    sr_word[SR_EXL_BIT]              = sr_exl_q;
    sr_word[SR_IE_BIT]               = sr_ie_q;
    cause_word                       = '0;
    cause_word[CAUSE_BD_BIT]         = cause_bd_q;
    cause_word[CAUSE_IP_MSB:CAUSE_IP_LSB]   = cause_ip_q;
    cause_word[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = cause_exc_q;
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      REG_SR:    cp0_rdata = sr_word;
      REG_CAUSE: cp0_rdata = cause_word;
      REG_EPC:   cp0_rdata = epc_q;
      REG_PRID:  cp0_rdata = PRID_VAL;
      default:   cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus randomized traffic checked
// against a word-level model of SR/Cause/EPC.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] HV   = 32'h0000_4180;
  localparam logic [31:0] PRID = 32'h4B55_0701;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic [31:0] epc_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_ctrl #(
    .HANDLER_VEC (HV),
    .PRID_VAL    (PRID)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_code_m (exc_code_m),
    .eret_m     (eret_m),
    .hw_int     (hw_int),
    .cp0_we     (cp0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .exc_req    (exc_req),
    .exc_pc     (exc_pc),
    .epc_out    (epc_out)
  );

  always #5 clk = ~clk;

  function automatic logic m_int_req();
    return (|(hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_exc_req();
    return reset && (m_int_req() || ((exc_code_m != 5'd0) && !m_sr[1]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic take_int, take;
    take_int = m_int_req();
    take     = m_exc_req();
    if (take) begin
      m_sr[1]      = 1'b1;
      m_cause[31]  = bd_m;
      m_cause[6:2] = take_int ? 5'd0 : exc_code_m;
      m_epc        = {pc_m[31:2], 2'b00} - (bd_m ? 32'd4 : 32'd0);
    end else begin
      if (eret_m) m_sr[1] = 1'b0;
      if (cp0_we && cp0_addr == 5'd12) m_sr = cp0_wdata & 32'h0000_FC03;
      if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata & 32'hFFFF_FFFC;
    end
    m_cause[15:10] = hw_int;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_m = 32'h0; bd_m = 1'b0; exc_code_m = 5'd0; eret_m = 1'b0;
    hw_int = 6'd0; cp0_we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'h0;
  endtask

  task automatic write_sr(input logic [31:0] v);
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = v;
    tick();
    cp0_we = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    exc_code_m = 5'd4;
    #1;
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL reset_exc_req: got %b want 0", exc_req); end
    n_cmp++; if (exc_pc !== HV) begin n_bad++; $display("FAIL reset_exc_pc: got %h want %h", exc_pc, HV); end
    cp0_addr = 5'd12; #1;
    n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_sr: got %h want 0", cp0_rdata); end
    cp0_addr = 5'd13; #1;
    n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_cause: got %h want 0", cp0_rdata); end
    cp0_addr = 5'd14; #1;
    n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_epc: got %h want 0", cp0_rdata); end
    cp0_addr = 5'd15; #1;
    n_cmp++; if (cp0_rdata !== PRID) begin n_bad++; $display("FAIL reset_prid: got %h want %h", cp0_rdata, PRID); end
    exc_code_m = 5'd0;
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_masked();
    write_sr(32'h0000_FC00);
    hw_int = 6'h3F; #1;
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL masked_req: got %b want 0", exc_req); end
    tick();
    cp0_addr = 5'd13; #1;
    n_cmp++; if (cp0_rdata !== 32'h0000_FC00) begin n_bad++; $display("FAIL masked_cause: got %h want 0000fc00", cp0_rdata); end
    hw_int = 6'd0;
    tick();
  endtask

  task automatic test_misaligned();
    write_sr(32'h0000_0401);
    cp0_addr = 5'd12; #1;
    n_cmp++; if (cp0_rdata !== 32'h0000_0401) begin n_bad++; $display("FAIL mis_sr_write: got %h want 00000401", cp0_rdata); end
    exc_code_m = 5'd4; pc_m = 32'h3006; bd_m = 1'b0; #1;
    n_cmp++; if (exc_req !== 1'b1) begin n_bad++; $display("FAIL mis_req: got %b want 1", exc_req); end
    tick();
    exc_code_m = 5'd0;
    cp0_addr = 5'd14; #1;
    n_cmp++; if (cp0_rdata !== 32'h3004) begin n_bad++; $display("FAIL mis_epc: got %h want 00003004", cp0_rdata); end
    n_cmp++; if (epc_out !== 32'h3004) begin n_bad++; $display("FAIL mis_epc_out: got %h want 00003004", epc_out); end
    cp0_addr = 5'd13; #1;
    n_cmp++; if (cp0_rdata !== 32'h0000_0010) begin n_bad++; $display("FAIL mis_cause: got %h want 00000010", cp0_rdata); end
    cp0_addr = 5'd12; #1;
    n_cmp++; if (cp0_rdata !== 32'h0000_0403) begin n_bad++; $display("FAIL mis_sr_exl: got %h want 00000403", cp0_rdata); end
    write_sr(32'h0000_0401);
  endtask

  task automatic test_delay_slot();
    hw_int = 6'b000001; bd_m = 1'b1; pc_m = 32'h3010; #1;
    n_cmp++; if (exc_req !== 1'b1) begin n_bad++; $display("FAIL ds_req: got %b want 1", exc_req); end
    tick();
    bd_m = 1'b0;
    cp0_addr = 5'd14; #1;
    n_cmp++; if (cp0_rdata !== 32'h300C) begin n_bad++; $display("FAIL ds_epc: got %h want 0000300c", cp0_rdata); end
    cp0_addr = 5'd13; #1;
    n_cmp++; if (cp0_rdata !== 32'h8000_0400) begin n_bad++; $display("FAIL ds_cause: got %h want 80000400", cp0_rdata); end
    hw_int = 6'd0;
    write_sr(32'h0000_0401);
  endtask

  task automatic test_nesting();
    write_sr(32'h0000_0403);
    exc_code_m = 5'd10; pc_m = 32'h5000; #1;
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL nest_req: got %b want 0", exc_req); end
    tick();
    exc_code_m = 5'd0;
    cp0_addr = 5'd14; #1;
    n_cmp++; if (cp0_rdata !== 32'h300C) begin n_bad++; $display("FAIL nest_epc_kept: got %h want 0000300c", cp0_rdata); end
    hw_int = 6'b000001; eret_m = 1'b1; #1;
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL nest_eret_req: got %b want 0", exc_req); end
    tick();
    eret_m = 1'b0;
    cp0_addr = 5'd12; #1;
    n_cmp++; if (cp0_rdata !== 32'h0000_0401) begin n_bad++; $display("FAIL nest_eret_sr: got %h want 00000401", cp0_rdata); end
    pc_m = 32'h6000; #1;
    n_cmp++; if (exc_req !== 1'b1) begin n_bad++; $display("FAIL nest_pending_req: got %b want 1", exc_req); end
    tick();
    hw_int = 6'd0;
    cp0_addr = 5'd14; #1;
    n_cmp++; if (cp0_rdata !== 32'h6000) begin n_bad++; $display("FAIL nest_epc: got %h want 00006000", cp0_rdata); end
    cp0_addr = 5'd13; #1;
    n_cmp++; if (cp0_rdata !== 32'h0000_0400) begin n_bad++; $display("FAIL nest_cause: got %h want 00000400", cp0_rdata); end
    write_sr(32'h0000_0401);
  endtask

  task automatic test_collision();
    hw_int = 6'b000001; pc_m = 32'h7008; exc_code_m = 5'd12;
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h4000; #1;
    n_cmp++; if (exc_req !== 1'b1) begin n_bad++; $display("FAIL coll_req: got %b want 1", exc_req); end
    tick();
    cp0_we = 1'b0; hw_int = 6'd0; exc_code_m = 5'd0;
    cp0_addr = 5'd14; #1;
    n_cmp++; if (cp0_rdata !== 32'h7008) begin n_bad++; $display("FAIL coll_epc: got %h want 00007008", cp0_rdata); end
    cp0_addr = 5'd13; #1;
    n_cmp++; if (cp0_rdata !== 32'h0000_0400) begin n_bad++; $display("FAIL coll_cause: got %h want 00000400", cp0_rdata); end
    write_sr(32'h0000_0401);
  endtask

  task automatic test_async_reset();
    exc_code_m = 5'd4; pc_m = 32'h8000;
    tick();
    #2 reset = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    #1;
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL arst_req: got %b want 0", exc_req); end
    cp0_addr = 5'd12; #1;
    n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL arst_sr: got %h want 0", cp0_rdata); end
    cp0_addr = 5'd13; #1;
    n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL arst_cause: got %h want 0", cp0_rdata); end
    cp0_addr = 5'd14; #1;
    n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL arst_epc: got %h want 0", cp0_rdata); end
    exc_code_m = 5'd0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [4:0] codes [8];
    codes = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
    for (int i = 0; i < 400; i++) begin
      pc_m       = $urandom;
      bd_m       = 1'($urandom);
      exc_code_m = codes[$urandom_range(0, 7)];
      eret_m     = ($urandom_range(0, 5) == 0);
      hw_int     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      cp0_we     = ($urandom_range(0, 3) == 0);
      cp0_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      cp0_wdata  = $urandom;
      #1;
      n_cmp++; if (exc_req !== m_exc_req()) begin n_bad++; $display("FAIL rnd_req[%0d]: got %b want %b", i, exc_req, m_exc_req()); end
      n_cmp++; if (epc_out !== m_epc) begin n_bad++; $display("FAIL rnd_epc_out[%0d]: got %h want %h", i, epc_out, m_epc); end
      n_cmp++; if (cp0_rdata !== m_read(cp0_addr)) begin n_bad++; $display("FAIL rnd_rdata[%0d] addr %0d: got %h want %h", i, cp0_addr, cp0_rdata, m_read(cp0_addr)); end
      n_cmp++; if (exc_pc !== HV) begin n_bad++; $display("FAIL rnd_exc_pc[%0d]: got %h want %h", i, exc_pc, HV); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_masked();
    test_misaligned();
    test_delay_slot();
    test_nesting();
    test_collision();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception controller for the P7 MIPS microsystem: the consumer end of the fetch-stage exception path. It collects the exception code carried down the pipeline from fetch (AdEL = 4 on misaligned or out-of-range PC) and the device interrupt lines. It raises a single flush/redirect request and records SR, Cause and EPC. It also serves `mtc0`/`mfc0` and supplies the `eret` return address back to next-PC selection.

## Interface
Parameters:
- `HANDLER_VEC`, default 32'h0000_4180: redirect target on any exception or interrupt.
- `PRID_VAL`, default 32'h4B55_0701: read-only PRId contents.

Ports:
- `clk`  input  1  Single clock; all state updates on rising edge.
- `reset`  input  1  Asynchronous, active-low (0 = reset); clears state immediately, no clock needed.
- `pc_m`  input  32  PC of the instruction in M stage.
- `bd_m`  input  1  M-stage instruction is in a branch delay slot.
- `exc_code_m`  input  5  Exception code accumulated for the M-stage instruction (0 = none); fetch AdEL arrives here as 4.
- `eret_m`  input  1  M-stage instruction is `eret`.
- `hw_int`  input  6  Device interrupt lines, level-sensitive.
- `cp0_we`  input  1  `mtc0` write strobe.
- `cp0_addr`  input  5  CP0 register number for read and write.
- `cp0_wdata`  input  32  `mtc0` data.
- `cp0_rdata`  output  32  `mfc0` data, combinational.
- `exc_req`  output  1  Flush F/D/E/M and load `HANDLER_VEC` into PC.
- `exc_pc`  output  32  Constant `HANDLER_VEC`.
- `epc_out`  output  32  Current EPC, the `eret` target.

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]. Other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]. Other bits read 0.
  - EPC (14): 32 bits, bits [1:0] always 0.
  - PRId (15): `PRID_VAL`.
- Interrupt pending: `int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL`.
- Exception pending: `ex_req = (exc_code_m != 0) & ~SR.EXL`.
- `exc_req = int_req | ex_req`. Interrupt has priority over exception.
- On `exc_req`:
  - SR.EXL <= 1.
  - Cause.ExcCode <= 0 if the request is an interrupt, else `exc_code_m`.
  - Cause.BD <= `bd_m`.
  - EPC <= `{pc_m[31:2],2'b00} - (bd_m ? 4 : 0)`.
- On `eret_m` with no `exc_req`: SR.EXL <= 0. No other field changes.
- Cause.IP <= `hw_int` every cycle, regardless of masks or EXL.
- `mtc0`:
  - Writes SR, or EPC with bits [1:0] forced to 0.
  - Writes to Cause, PRId or unimplemented addresses are ignored.
  - Suppressed in any cycle where `exc_req`=1.
- `mfc0`: returns the current register value. Unimplemented addresses read 0.
- Arithmetic: EPC subtraction is 32-bit modulo. `pc_m` = 0 with `bd_m` gives 32'hFFFF_FFFC.

## Timing
- `exc_req`, `cp0_rdata`, `exc_pc` and `epc_out` are combinational from current state and inputs; zero-cycle latency.
- All register updates take effect at the next rising edge. `mfc0` in the same cycle as `mtc0` returns the old value; the pipeline stalls for the hazard.
- Simultaneous events:
  - `exc_req` with `mtc0`: exception wins, write dropped.
  - `exc_req` with `eret_m`: exception wins, EXL stays 1.
  - Interrupt with a nonzero `exc_code_m`: ExcCode is 0, EPC still records `pc_m`.
- While EXL=1, nested exceptions and interrupts are ignored. `exc_req` stays 0 even if `exc_code_m` is nonzero.
- Reset values: SR=0, Cause=0 (IP resamples on the first edge after release), EPC=0, `exc_req`=0, `cp0_rdata` = value of the addressed register (PRId still reads `PRID_VAL`).
- Reset asserted mid-handler clears EXL immediately. `exc_req` is forced to 0 while reset=0.

## Structure
- Package `cp0_pkg`:
  - Register numbers (SR=12, CAUSE=13, EPC=14, PRID=15).
  - Field bit positions.
  - Exception codes: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - `HANDLER_VEC` default.
- One combinational sub-module `cp0_exc_arbiter`: computes `int_req`, `ex_req`, the selected ExcCode and the EPC value. The top level holds the registers and the read mux.

## Test plan
- Misaligned fetch: SR=0x0000_0401 (IM[10]=1, IE=1), `exc_code_m`=4, `pc_m`=0x3006, `bd_m`=0 -> `exc_req`=1 that cycle; next edge EPC=0x3004, Cause.ExcCode=4, SR.EXL=1.
- Delay-slot interrupt: `hw_int`=6'b000001, IM enabled, `bd_m`=1, `pc_m`=0x3010 -> EPC=0x300C, Cause=0x8000_0400.
- Masked interrupt: IE=0, `hw_int`=6'b111111 -> `exc_req`=0; Cause reads 0x0000_FC00 one cycle later.
- Nesting: EXL=1 with `exc_code_m`=10 -> no request, EPC unchanged. `eret_m` -> EXL=0 next edge; pending interrupt fires the following cycle.
- Collision: `mtc0` EPC=0x4000 in the same cycle as an interrupt -> EPC = victim `pc_m`; 0x4000 discarded.
- Async reset: pull `reset` low between edges while EXL=1 -> SR, Cause and EPC read 0 before the next edge.
